// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: turns raw device frames into toggle-flagged key events.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_gen #(
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic          clk_prev_reg;
    logic          fall_edge;
    logic          data_s;

    state_t        state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [TW-1:0] to_cnt_reg;
    logic          ext_flag_reg;
    logic          brk_flag_reg;
    logic [10:0]   ps2_key_reg;
    logic          err_reg;
    logic          frame_ok;

    // Synchronizers reset to 1 so an idle bus never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            clk_prev_reg  <= clk_sync_reg[1];
        end
    end

    assign fall_edge = clk_prev_reg & ~clk_sync_reg[1];
    assign data_s    = data_sync_reg[1];

`ifdef PS2_PARITY_CHECK_EN
    logic parity_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_reg <= 1'b0;
        end else if (fall_edge && state_reg == PARITY) begin
            parity_reg <= data_s;
        end
    end

    // Odd parity: data plus parity bit must carry an odd number of ones.
    assign frame_ok = data_s & (^{shift_reg, parity_reg});
`else
    assign frame_ok = data_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'd0;
            to_cnt_reg   <= '0;
            ext_flag_reg <= 1'b0;
            brk_flag_reg <= 1'b0;
            ps2_key_reg  <= 11'd0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (fall_edge) begin
                to_cnt_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (!data_s) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_s, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end
                    PARITY: begin
                        state_reg <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        if (!frame_ok) begin
                            err_reg <= 1'b1;
                        end else begin
                            case (shift_reg)
                                8'hE0: ext_flag_reg <= 1'b1;
                                8'hF0: brk_flag_reg <= 1'b1;
                                8'hE1: begin
                                end
                                default: begin
                                    ps2_key_reg  <= {~ps2_key_reg[10], ~brk_flag_reg,
                                                     ext_flag_reg, shift_reg};
                                    ext_flag_reg <= 1'b0;
                                    brk_flag_reg <= 1'b0;
                                end
                            endcase
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end else if (state_reg != IDLE) begin
                // Stalled device clock: abandon the partial frame.
                if (to_cnt_reg == TO_LAST) begin
                    state_reg <= IDLE;
                    err_reg   <= 1'b1;
                end else if (to_cnt_reg != '1) begin
                    to_cnt_reg <= to_cnt_reg + TW'(1);
                end
            end
        end
    end

    assign ps2_key = ps2_key_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_ps2_key_gen.sv
// Scoreboard bench for ps2_key_gen: frames are modelled when sent, events checked as they appear.
module tb_ps2_key_gen;

    localparam int TO   = 300;
    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    ps2_key_gen #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [10:0] key;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    bit   m_tog = 1'b0;
    bit   m_ext = 1'b0;
    bit   m_brk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_evt(input bit is_err, input logic [10:0] key, input int lat);
        exp_t e;
        e.is_err = is_err;
        e.key    = key;
        e.lat    = lat;
        exp_q.push_back(e);
    endtask

    // Reference behaviour of the decoder for one completed frame.
    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            push_evt(1'b1, 11'd0, 3);
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b != 8'hE1) begin
            m_tog = ~m_tog;
            push_evt(1'b0, {m_tog, ~m_brk, m_ext, b}, 3);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        logic par;
        bit   ok;
        par = (~^b) ^ bad_par;
        ok  = stop;
`ifdef PS2_PARITY_CHECK_EN
        ok  = stop && !bad_par;
`endif
        model_frame(b, ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        repeat (4) @(negedge clk);
        check("drain", exp_q.size(), 0);
        $display("[TB] frame 0x%02h par_bad=%0d stop=%0d -> ps2_key=0x%03h", b, bad_par, stop, ps2_key);
    endtask

    // Monitor: every err pulse or ps2_key change must match the head of the queue.
    initial begin
        logic [10:0] last_key;
        exp_t e;
        last_key = 11'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_key = ps2_key;
            end else begin
                if (err || ps2_key != last_key) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_evt", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("evt_kind", {31'd0, err}, {31'd0, e.is_err});
                        if (!e.is_err) check("evt_key", ps2_key, e.key);
                        if (e.lat >= 0) check("evt_lat", cyc - fall_cyc, e.lat);
                        $display("[TB] event err=%0d ps2_key=0x%03h at +%0d clk", err, ps2_key, cyc - fall_cyc);
                    end
                end
                last_key = ps2_key;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_key", ps2_key, 0);
        check("rst_err", {31'd0, err}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'h75, 1'b0, 1'b1);
        check("key_75", ps2_key, 11'h675);

        send_frame(8'hE0, 1'b0, 1'b1);
        check("e0_hold", ps2_key, 11'h675);
        send_frame(8'h75, 1'b0, 1'b1);

        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h14, 1'b0, 1'b1);
        check("brk_14", ps2_key[9:0], 10'h014);
        send_frame(8'h14, 1'b0, 1'b1);

        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);

        send_frame(8'hE1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);

        // Bad parity, then a bad stop bit.
        send_frame(8'h16, 1'b1, 1'b1);
        send_frame(8'h29, 1'b0, 1'b0);

        // Stray clock pulse with data high while idle.
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        check("idle_stray", exp_q.size(), 0);

        // Stall after four data bits.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        push_evt(1'b1, 11'd0, TO + 3);
        repeat (TO + 20) @(negedge clk);
        check("timeout_drain", exp_q.size(), 0);
        $display("[TB] timeout frame abandoned, ps2_key=0x%03h", ps2_key);
        send_frame(8'h1E, 1'b0, 1'b1);

        // Reset in the middle of frame 0x2E.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h2E >> i));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_key", ps2_key, 0);
        check("mid_rst_err", {31'd0, err}, 0);
        m_tog = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h2E, 1'b0, 1'b1);
        check("post_rst_2e", ps2_key, 11'h62E);

        repeat (10) @(negedge clk);
        check("final_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
